// File: rtl/ahb_cfg_bridge.sv
// AHB-Lite slave front end for a peripheral configuration register bank.
// Turns word-sized AHB transfers into single-cycle read/write strobes and returns the bank's read data.
module ahb_cfg_bridge #(
    parameter int unsigned AW   = 12,
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsel_i,
    input  logic [AW-1:0] haddr_i,
    input  logic [1:0]    htrans_i,
    input  logic          hwrite_i,
    input  logic [2:0]    hsize_i,
    input  logic [DW-1:0] hwdata_i,
    input  logic          hready_i,
    output logic          hreadyout_o,
    output logic          hresp_o,
    output logic [DW-1:0] hrdata_o,
    output logic [AW-3:0] reg_addr_o,
    output logic          reg_ren_o,
    output logic          reg_wen_o,
    output logic [DW-1:0] reg_wdata_o,
    input  logic [DW-1:0] reg_rdata_i
);

    localparam int unsigned IW = AW - 2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_ERR1 = 3'd4;
    localparam logic [2:0] S_ERR2 = 3'd5;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [IW-1:0] idx;
    logic          accept;
    logic          req_err;

    // Address-phase decode; RD1 and ERR1 hold HREADY low so no new phase can start there
    always_comb begin
        accept  = hsel_i && hready_i && htrans_i[1] && (state != S_RD1) && (state != S_ERR1);
        req_err = (hsize_i != 3'b010) || (haddr_i[1:0] != 2'b00)
                  || (haddr_i[AW-1:2] >= IW'(NREG));
    end

    always_comb begin
        state_nxt = S_IDLE;
        if (state == S_RD1) begin
            state_nxt = S_RD2;
        end else if (state == S_ERR1) begin
            state_nxt = S_ERR2;
        end else if (accept) begin
            if (req_err)       state_nxt = S_ERR1;
            else if (hwrite_i) state_nxt = S_WR;
            else               state_nxt = S_RD1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            hrdata_o <= '0;
        end else begin
            state <= state_nxt;
            if (accept) idx <= haddr_i[AW-1:2];
            if (state == S_RD1) hrdata_o <= reg_rdata_i;
        end
    end

    // Data-phase outputs decoded from the state register; write data passes straight through
    always_comb begin
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        reg_ren_o   = 1'b0;
        reg_wen_o   = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        case (state)
            S_WR: begin
                reg_wen_o   = 1'b1;
                reg_addr_o  = idx;
                reg_wdata_o = hwdata_i;
            end
            S_RD1: begin
                reg_ren_o   = 1'b1;
                reg_addr_o  = idx;
                hreadyout_o = 1'b0;
            end
            S_ERR1: begin
                hresp_o     = 1'b1;
                hreadyout_o = 1'b0;
            end
            S_ERR2: begin
                hresp_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_cfg_bridge.sv
// Directed self-checking bench for ahb_cfg_bridge with a small register bank model.
module tb_ahb_cfg_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel;
    logic [11:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [9:0]  reg_addr;
    logic        reg_ren;
    logic        reg_wen;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    logic [31:0] bank [16];
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ahb_cfg_bridge dut (
        .clk(clk), .rst_n(rst_n), .hsel_i(hsel), .haddr_i(haddr), .htrans_i(htrans),
        .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata), .hready_i(hready),
        .hreadyout_o(hreadyout), .hresp_o(hresp), .hrdata_o(hrdata),
        .reg_addr_o(reg_addr), .reg_ren_o(reg_ren), .reg_wen_o(reg_wen),
        .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata)
    );

    // Bank returns zero unless read-enabled
    assign reg_rdata = (reg_ren && reg_addr < 10'd16) ? bank[reg_addr[3:0]] : 32'h0;
    always @(posedge clk) if (reg_wen && reg_addr < 10'd16) bank[reg_addr[3:0]] <= reg_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [11:0] a, input logic w, input logic [2:0] sz);
        hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz; hready = 1'b1;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 12'h0; hsize = 3'b010; hready = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_idle(); hwdata = 32'hFFFF_FFFF;
        tick(); tick();
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp",     32'(hresp),     32'd0);
        chk("rst_hrdata",    hrdata,         32'd0);
        chk("rst_strobes",   {30'd0, reg_ren, reg_wen}, 32'd0);
        chk("rst_addr",      32'(reg_addr),  32'd0);
        chk("rst_wdata",     reg_wdata,      32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        addr_phase(12'h008, 1'b1, 3'b010);
        tick();
        bus_idle(); hwdata = 32'hA5A5_0003; #1;
        chk("wr_wen",       32'(reg_wen),   32'd1);
        chk("wr_ren",       32'(reg_ren),   32'd0);
        chk("wr_addr",      32'(reg_addr),  32'd2);
        chk("wr_wdata",     reg_wdata,      32'hA5A5_0003);
        chk("wr_hreadyout", 32'(hreadyout), 32'd1);
        chk("wr_hresp",     32'(hresp),     32'd0);
        tick();
        chk("wr_bank",      bank[2],        32'hA5A5_0003);
        chk("idle_wen",     32'(reg_wen),   32'd0);
        chk("idle_wdata0",  reg_wdata,      32'd0);
    endtask

    task automatic test_read();
        bank[3] = 32'h1234_5678;
        addr_phase(12'h00C, 1'b0, 3'b010);
        tick();
        bus_idle(); #1;
        chk("rd1_ren",       32'(reg_ren),   32'd1);
        chk("rd1_wen",       32'(reg_wen),   32'd0);
        chk("rd1_addr",      32'(reg_addr),  32'd3);
        chk("rd1_hreadyout", 32'(hreadyout), 32'd0);
        tick();
        chk("rd2_hrdata",    hrdata,         32'h1234_5678);
        chk("rd2_hreadyout", 32'(hreadyout), 32'd1);
        chk("rd2_hresp",     32'(hresp),     32'd0);
        chk("rd2_ren",       32'(reg_ren),   32'd0);
        tick();
        chk("rd_hold",       hrdata,         32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        int waits;
        waits = 0;
        addr_phase(12'h004, 1'b1, 3'b010);
        tick();
        hwdata = 32'hDEAD_BEEF;
        addr_phase(12'h004, 1'b0, 3'b010); #1;
        chk("b2b_wen",   32'(reg_wen),  32'd1);
        chk("b2b_waddr", 32'(reg_addr), 32'd1);
        tick();
        bus_idle(); #1;
        if (!hreadyout) waits++;
        chk("b2b_ren",   32'(reg_ren),  32'd1);
        chk("b2b_raddr", 32'(reg_addr), 32'd1);
        tick();
        if (!hreadyout) waits++;
        chk("b2b_rdata", hrdata,        32'hDEAD_BEEF);
        chk("b2b_waits", 32'(waits),    32'd1);
        // A following write must not disturb the captured read data
        addr_phase(12'h000, 1'b1, 3'b010);
        tick();
        bus_idle(); hwdata = 32'h0BAD_F00D;
        tick();
        chk("b2b_hold",  hrdata,        32'hDEAD_BEEF);
        chk("b2b_bank0", bank[0],       32'h0BAD_F00D);
    endtask

    task automatic test_error();
        addr_phase(12'h040, 1'b0, 3'b010);
        tick();
        bus_idle(); #1;
        chk("e1_hresp",     32'(hresp),     32'd1);
        chk("e1_hreadyout", 32'(hreadyout), 32'd0);
        chk("e1_strobes",   {30'd0, reg_ren, reg_wen}, 32'd0);
        tick();
        chk("e2_hresp",     32'(hresp),     32'd1);
        chk("e2_hreadyout", 32'(hreadyout), 32'd1);
        addr_phase(12'h002, 1'b1, 3'b001);
        tick();
        bus_idle(); hwdata = 32'h5555_5555; #1;
        chk("e3_hresp",     32'(hresp),     32'd1);
        chk("e3_hreadyout", 32'(hreadyout), 32'd0);
        chk("e3_strobes",   {30'd0, reg_ren, reg_wen}, 32'd0);
        tick();
        chk("e4_hresp",     32'(hresp),     32'd1);
        chk("e4_hreadyout", 32'(hreadyout), 32'd1);
        chk("e4_strobes",   {30'd0, reg_ren, reg_wen}, 32'd0);
        tick();
        chk("e5_hresp",     32'(hresp),     32'd0);
        chk("e5_bank0",     bank[0],        32'h0BAD_F00D);
    endtask

    task automatic test_no_accept();
        addr_phase(12'h008, 1'b1, 3'b010); hready = 1'b0;
        tick();
        hready = 1'b1; htrans = 2'b01; #1;
        chk("na_hready_strobes", {30'd0, reg_ren, reg_wen}, 32'd0);
        chk("na_hready_rdy",     32'(hreadyout), 32'd1);
        tick();
        hsel = 1'b0; htrans = 2'b10; #1;
        chk("na_busy_strobes",   {30'd0, reg_ren, reg_wen}, 32'd0);
        chk("na_busy_rdy",       32'(hreadyout), 32'd1);
        tick();
        bus_idle(); #1;
        chk("na_nosel_strobes",  {30'd0, reg_ren, reg_wen}, 32'd0);
        chk("na_nosel_hresp",    32'(hresp),     32'd0);
        chk("na_bank2",          bank[2],        32'hA5A5_0003);
    endtask

    task automatic test_reset_mid_read();
        bank[5] = 32'hCAFE_0005;
        addr_phase(12'h014, 1'b0, 3'b010);
        tick();
        bus_idle(); #1;
        chk("mr_rd1_ren",   32'(reg_ren),   32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_ren",       32'(reg_ren),   32'd0);
        chk("mr_hreadyout", 32'(hreadyout), 32'd1);
        chk("mr_hrdata",    hrdata,         32'd0);
        rst_n = 1'b1;
        tick();
        chk("mr_no_rd2",    hrdata,         32'd0);
        chk("mr_rdy",       32'(hreadyout), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_error();
        test_no_accept();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
